decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- MIPS ID stage, directly downstream of the fetch module.
- Consumes the IF/ID pair (PC+4, instruction) and owns the 32x32 register file with a WB write port.
- Resolves beq/bne/j in ID, detects load-use and branch-operand hazards, and drives fetch's control inputs.
- Registers decoded operands and control into the ID/EX pipeline register.

Parameters:
NB_BITS, 32, datapath/instruction width
NB_REG, 5, register index width
N_REGS, 32, register file depth

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_if_id_pc  in  32  PC+4 of instruction in ID
i_if_id_instr  in  32  instruction in ID
i_wb_we  in  1  register file write enable
i_wb_addr  in  5  write index
i_wb_data  in  32  write data
i_ex_mem_rd  in  5  EX/MEM destination register
i_ex_mem_we  in  1  EX/MEM writes a register
i_ex_mem_mem_rd  in  1  EX/MEM instruction is a load
i_ex_mem_alu  in  32  EX/MEM ALU result
o_brq_addr  out  32  branch target to fetch
o_jmp_addr  out  32  jump target to fetch
o_ctr_beq  out  1  branch taken (combinational)
o_ctr_jmp  out  1  jump (combinational)
o_ctr_flush  out  1  flush IF/ID (combinational)
o_pc_we  out  1  PC write enable (0 = stall)
o_if_id_we  out  1  IF/ID write enable (0 = stall)
o_id_ex_pc, o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm  out  32 each  registered
o_id_ex_rs, o_id_ex_rt, o_id_ex_rd  out  5 each  registered; rd = resolved destination
o_id_ex_alu_op  out  4  registered
o_id_ex_alu_src, o_id_ex_mem_rd, o_id_ex_mem_wr, o_id_ex_reg_we, o_id_ex_mem_to_reg  out  1 each  registered

Behaviour:
- Reset (i_rst=0, asynchronous): all ID/EX outputs 0; all registers 0. Combinational outputs settle to o_pc_we=1, o_if_id_we=1, beq/jmp/flush=0.
- Supported ops: R-type add/sub/and/or/slt, addi, lw, sw, beq, bne, j. Any other opcode/funct decodes as a NOP (all control 0). 0x00000000 is a NOP.
- Destination: rd for R-type, rt for addi/lw, 0 otherwise.
- Immediate is sign-extended.
- alu_op codes: 0 add, 1 sub, 2 and, 3 or, 4 slt.
- Register file:
  - $0 reads 0 and writes to it are ignored.
  - Write on posedge when i_wb_we=1.
  - Read is write-first: if i_wb_we and i_wb_addr equals the read index (≠0), i_wb_data is returned the same cycle.
- Branch operand forwarding: if i_ex_mem_we, !i_ex_mem_mem_rd, and i_ex_mem_rd≠0 matches rs/rt, use i_ex_mem_alu. Priority is EX/MEM, then WB bypass, then RF.
- Stall conditions:
  - Load-use: ID/EX mem_rd=1 and its rd≠0 matches rs, or rt for R-type/sw/beq/bne.
  - Branch hazard: a beq/bne source matches ID/EX rd≠0 with reg_we=1.
  - Branch hazard: a beq/bne source matches an EX/MEM load's rd≠0.
- On stall:
  - o_pc_we=0 and o_if_id_we=0.
  - Next ID/EX gets a bubble (all control 0, data 0).
  - o_ctr_beq, o_ctr_jmp and o_ctr_flush are forced to 0.
- Branch (no stall):
  - beq taken when operands are equal; bne taken when they differ.
  - Taken: o_ctr_beq=1, o_ctr_flush=1, o_brq_addr = i_if_id_pc + (sext(imm)<<2).
  - Branch is latched into ID/EX with reg_we=0.
- Jump (no stall):
  - o_ctr_jmp=1, o_ctr_flush=1.
  - o_jmp_addr = {i_if_id_pc[31:28], instr[25:0], 2'b00}.
- o_brq_addr and o_jmp_addr are driven combinationally every cycle regardless of the control bits.
- ID/EX latency: 1 cycle. Updated every posedge when not in reset.
- Reset mid-stall clears ID/EX immediately; the stall releases once the reset clears the registers.

Test Plan:
- Reset → all o_id_ex_* = 0 and o_pc_we=1. Release; instr 0x20080005 (addi $8,$0,5) → next cycle o_id_ex_imm=5, rd=8, reg_we=1, alu_src=1.
- WB bypass: i_wb_we=1, i_wb_addr=9, i_wb_data=0x1234 while ID has add $10,$9,$0 → o_id_ex_rs_data=0x1234 next cycle.
- Load-use: lw $2,0($1) followed by add $3,$2,$2 → one cycle with o_pc_we=0, o_if_id_we=0, then a bubble in ID/EX, then the add issues.
- beq $4,$4,+3 at i_if_id_pc=0x20 (no hazard) → o_ctr_beq=1, o_ctr_flush=1, o_brq_addr=0x2C. bne with equal operands → o_ctr_beq=0.
- j 0x0000040 at i_if_id_pc=0x10000004 → o_ctr_jmp=1, o_jmp_addr=0x10000100. A write to $0 with 0xFFFF → $0 still reads 0.
- EX/MEM forward: i_ex_mem_we=1, i_ex_mem_rd=5, i_ex_mem_alu=7, RF $5=0, ID has beq $5,$6 with $6=7 → taken. Same case with i_ex_mem_mem_rd=1 → stall, not taken.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS ID stage: instruction decode, 32x32 register file with write-first
// WB port, ID-stage branch/jump resolution, hazard detection and the ID/EX
// pipeline register.
module decode_stage #(
   parameter int unsigned NB_BITS = 32,
   parameter int unsigned NB_REG  = 5,
   parameter int unsigned N_REGS  = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_BITS-1:0] i_if_id_pc,
   input  logic [NB_BITS-1:0] i_if_id_instr,
   input  logic               i_wb_we,
   input  logic [NB_REG-1:0]  i_wb_addr,
   input  logic [NB_BITS-1:0] i_wb_data,
   input  logic [NB_REG-1:0]  i_ex_mem_rd,
   input  logic               i_ex_mem_we,
   input  logic               i_ex_mem_mem_rd,
   input  logic [NB_BITS-1:0] i_ex_mem_alu,
   output logic [NB_BITS-1:0] o_brq_addr,
   output logic [NB_BITS-1:0] o_jmp_addr,
   output logic               o_ctr_beq,
   output logic               o_ctr_jmp,
   output logic               o_ctr_flush,
   output logic               o_pc_we,
   output logic               o_if_id_we,
   output logic [NB_BITS-1:0] o_id_ex_pc,
   output logic [NB_BITS-1:0] o_id_ex_rs_data,
   output logic [NB_BITS-1:0] o_id_ex_rt_data,
   output logic [NB_BITS-1:0] o_id_ex_imm,
   output logic [NB_REG-1:0]  o_id_ex_rs,
   output logic [NB_REG-1:0]  o_id_ex_rt,
   output logic [NB_REG-1:0]  o_id_ex_rd,
   output logic [3:0]         o_id_ex_alu_op,
   output logic               o_id_ex_alu_src,
   output logic               o_id_ex_mem_rd,
   output logic               o_id_ex_mem_wr,
   output logic               o_id_ex_reg_we,
   output logic               o_id_ex_mem_to_reg
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;

   // instruction fields
   logic [5:0]         op;
   logic [5:0]         funct;
   logic [NB_REG-1:0]  rs;
   logic [NB_REG-1:0]  rt;
   logic [NB_REG-1:0]  rd;
   logic [NB_BITS-1:0] imm_sext;

   assign op       = i_if_id_instr[31:26];
   assign rs       = i_if_id_instr[25:21];
   assign rt       = i_if_id_instr[20:16];
   assign rd       = i_if_id_instr[15:11];
   assign funct    = i_if_id_instr[5:0];
   assign imm_sext = {{(NB_BITS-16){i_if_id_instr[15]}}, i_if_id_instr[15:0]};

   // decoded control
   logic [3:0]        dec_alu_op;
   logic              dec_alu_src;
   logic              dec_mem_rd;
   logic              dec_mem_wr;
   logic              dec_reg_we;
   logic              dec_mem_to_reg;
   logic              dec_beq;
   logic              dec_bne;
   logic              dec_jmp;
   logic              dec_uses_rt;
   logic [NB_REG-1:0] dec_dst;

   // main decoder; anything unrecognised falls through as a NOP
   always_comb begin
      dec_alu_op     = ALU_ADD;
      dec_alu_src    = 1'b0;
      dec_mem_rd     = 1'b0;
      dec_mem_wr     = 1'b0;
      dec_reg_we     = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_beq        = 1'b0;
      dec_bne        = 1'b0;
      dec_jmp        = 1'b0;
      dec_uses_rt    = 1'b0;
      dec_dst        = '0;
      unique case (op)
         OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                funct == FN_OR  || funct == FN_SLT) begin
               dec_reg_we  = 1'b1;
               dec_uses_rt = 1'b1;
               dec_dst     = rd;
               unique case (funct)
                  FN_SUB:  dec_alu_op = ALU_SUB;
                  FN_AND:  dec_alu_op = ALU_AND;
                  FN_OR:   dec_alu_op = ALU_OR;
                  FN_SLT:  dec_alu_op = ALU_SLT;
                  default: dec_alu_op = ALU_ADD;
               endcase
            end
         end
         OP_ADDI: begin
            dec_alu_src = 1'b1;
            dec_reg_we  = 1'b1;
            dec_dst     = rt;
         end
         OP_LW: begin
            dec_alu_src    = 1'b1;
            dec_mem_rd     = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_we     = 1'b1;
            dec_dst        = rt;
         end
         OP_SW: begin
            dec_alu_src = 1'b1;
            dec_mem_wr  = 1'b1;
            dec_uses_rt = 1'b1;
         end
         // branches carry a subtract downstream; they never write a register
         OP_BEQ: begin
            dec_alu_op  = ALU_SUB;
            dec_beq     = 1'b1;
            dec_uses_rt = 1'b1;
         end
         OP_BNE: begin
            dec_alu_op  = ALU_SUB;
            dec_bne     = 1'b1;
            dec_uses_rt = 1'b1;
         end
         OP_J:    dec_jmp = 1'b1;
         default: ;
      endcase
   end

   // register file, $0 never written
   logic [NB_BITS-1:0] rf_q [N_REGS];

   // WB write port
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < int'(N_REGS); i++) rf_q[i] <= '0;
      end else if (i_wb_we && i_wb_addr != '0) begin
         rf_q[i_wb_addr] <= i_wb_data;
      end
   end

   // write-first register reads
   logic [NB_BITS-1:0] rs_rf;
   logic [NB_BITS-1:0] rt_rf;

   always_comb begin
      rs_rf = rf_q[rs];
      rt_rf = rf_q[rt];
      if (i_wb_we && i_wb_addr == rs) rs_rf = i_wb_data;
      if (i_wb_we && i_wb_addr == rt) rt_rf = i_wb_data;
      if (rs == '0) rs_rf = '0;
      if (rt == '0) rt_rf = '0;
   end

   // branch comparator operands with EX/MEM ALU forwarding on top
   logic [NB_BITS-1:0] rs_br;
   logic [NB_BITS-1:0] rt_br;
   logic               fwd_ok;

   assign fwd_ok = i_ex_mem_we && !i_ex_mem_mem_rd && i_ex_mem_rd != '0;
   assign rs_br  = (fwd_ok && i_ex_mem_rd == rs) ? i_ex_mem_alu : rs_rf;
   assign rt_br  = (fwd_ok && i_ex_mem_rd == rt) ? i_ex_mem_alu : rt_rf;

   // ID/EX state
   logic [NB_BITS-1:0] id_ex_pc_q,      id_ex_pc_d;
   logic [NB_BITS-1:0] id_ex_rs_data_q, id_ex_rs_data_d;
   logic [NB_BITS-1:0] id_ex_rt_data_q, id_ex_rt_data_d;
   logic [NB_BITS-1:0] id_ex_imm_q,     id_ex_imm_d;
   logic [NB_REG-1:0]  id_ex_rs_q,      id_ex_rs_d;
   logic [NB_REG-1:0]  id_ex_rt_q,      id_ex_rt_d;
   logic [NB_REG-1:0]  id_ex_rd_q,      id_ex_rd_d;
   logic [3:0]         id_ex_alu_op_q,  id_ex_alu_op_d;
   logic               id_ex_alu_src_q, id_ex_alu_src_d;
   logic               id_ex_mem_rd_q,  id_ex_mem_rd_d;
   logic               id_ex_mem_wr_q,  id_ex_mem_wr_d;
   logic               id_ex_reg_we_q,  id_ex_reg_we_d;
   logic               id_ex_m2r_q,     id_ex_m2r_d;

   // hazard detection; held off while in reset so fetch runs freely
   logic is_branch;
   logic load_use;
   logic br_idex_haz;
   logic br_exmem_haz;
   logic stall;

   assign is_branch    = dec_beq || dec_bne;
   assign load_use     = id_ex_mem_rd_q && id_ex_rd_q != '0 &&
                         (id_ex_rd_q == rs || (dec_uses_rt && id_ex_rd_q == rt));
   assign br_idex_haz  = is_branch && id_ex_reg_we_q && id_ex_rd_q != '0 &&
                         (id_ex_rd_q == rs || id_ex_rd_q == rt);
   assign br_exmem_haz = is_branch && i_ex_mem_mem_rd && i_ex_mem_rd != '0 &&
                         (i_ex_mem_rd == rs || i_ex_mem_rd == rt);
   assign stall        = i_rst && (load_use || br_idex_haz || br_exmem_haz);

   // branch/jump resolution toward fetch
   logic br_taken;

   assign br_taken    = !stall && i_rst &&
                        ((dec_beq && rs_br == rt_br) || (dec_bne && rs_br != rt_br));
   assign o_ctr_beq   = br_taken;
   assign o_ctr_jmp   = !stall && i_rst && dec_jmp;
   assign o_ctr_flush = o_ctr_beq || o_ctr_jmp;
   assign o_pc_we     = !stall;
   assign o_if_id_we  = !stall;
   assign o_brq_addr  = i_if_id_pc + {imm_sext[NB_BITS-3:0], 2'b00};
   assign o_jmp_addr  = {i_if_id_pc[NB_BITS-1:NB_BITS-4], i_if_id_instr[25:0], 2'b00};

   // next ID/EX contents: decoded instruction, or a bubble when stalled
   always_comb begin
      id_ex_pc_d      = '0;
      id_ex_rs_data_d = '0;
      id_ex_rt_data_d = '0;
      id_ex_imm_d     = '0;
      id_ex_rs_d      = '0;
      id_ex_rt_d      = '0;
      id_ex_rd_d      = '0;
      id_ex_alu_op_d  = '0;
      id_ex_alu_src_d = 1'b0;
      id_ex_mem_rd_d  = 1'b0;
      id_ex_mem_wr_d  = 1'b0;
      id_ex_reg_we_d  = 1'b0;
      id_ex_m2r_d     = 1'b0;
      if (!stall) begin
         id_ex_pc_d      = i_if_id_pc;
         id_ex_rs_data_d = rs_rf;
         id_ex_rt_data_d = rt_rf;
         id_ex_imm_d     = imm_sext;
         id_ex_rs_d      = rs;
         id_ex_rt_d      = rt;
         id_ex_rd_d      = dec_dst;
         id_ex_alu_op_d  = dec_alu_op;
         id_ex_alu_src_d = dec_alu_src;
         id_ex_mem_rd_d  = dec_mem_rd;
         id_ex_mem_wr_d  = dec_mem_wr;
         id_ex_reg_we_d  = dec_reg_we;
         id_ex_m2r_d     = dec_mem_to_reg;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         id_ex_pc_q      <= '0;
         id_ex_rs_data_q <= '0;
         id_ex_rt_data_q <= '0;
         id_ex_imm_q     <= '0;
         id_ex_rs_q      <= '0;
         id_ex_rt_q      <= '0;
         id_ex_rd_q      <= '0;
         id_ex_alu_op_q  <= '0;
         id_ex_alu_src_q <= 1'b0;
         id_ex_mem_rd_q  <= 1'b0;
         id_ex_mem_wr_q  <= 1'b0;
         id_ex_reg_we_q  <= 1'b0;
         id_ex_m2r_q     <= 1'b0;
      end else begin
         id_ex_pc_q      <= id_ex_pc_d;
         id_ex_rs_data_q <= id_ex_rs_data_d;
         id_ex_rt_data_q <= id_ex_rt_data_d;
         id_ex_imm_q     <= id_ex_imm_d;
         id_ex_rs_q      <= id_ex_rs_d;
         id_ex_rt_q      <= id_ex_rt_d;
         id_ex_rd_q      <= id_ex_rd_d;
         id_ex_alu_op_q  <= id_ex_alu_op_d;
         id_ex_alu_src_q <= id_ex_alu_src_d;
         id_ex_mem_rd_q  <= id_ex_mem_rd_d;
         id_ex_mem_wr_q  <= id_ex_mem_wr_d;
         id_ex_reg_we_q  <= id_ex_reg_we_d;
         id_ex_m2r_q     <= id_ex_m2r_d;
      end
   end

   assign o_id_ex_pc         = id_ex_pc_q;
   assign o_id_ex_rs_data    = id_ex_rs_data_q;
   assign o_id_ex_rt_data    = id_ex_rt_data_q;
   assign o_id_ex_imm        = id_ex_imm_q;
   assign o_id_ex_rs         = id_ex_rs_q;
   assign o_id_ex_rt         = id_ex_rt_q;
   assign o_id_ex_rd         = id_ex_rd_q;
   assign o_id_ex_alu_op     = id_ex_alu_op_q;
   assign o_id_ex_alu_src    = id_ex_alu_src_q;
   assign o_id_ex_mem_rd     = id_ex_mem_rd_q;
   assign o_id_ex_mem_wr     = id_ex_mem_wr_q;
   assign o_id_ex_reg_we     = id_ex_reg_we_q;
   assign o_id_ex_mem_to_reg = id_ex_m2r_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction sequence, ID/EX results
// checked through an expected-value queue, fetch controls checked mid-cycle.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_we;
      logic        mem_to_reg;
   } idex_t;

   logic        clk;
   logic        rst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  ex_mem_rd;
   logic        ex_mem_we;
   logic        ex_mem_mem_rd;
   logic [31:0] ex_mem_alu;
   logic [31:0] brq_addr;
   logic [31:0] jmp_addr;
   logic        ctr_beq;
   logic        ctr_jmp;
   logic        ctr_flush;
   logic        pc_we;
   logic        if_id_we;
   idex_t       dut_v;

   int n_chk  = 0;
   int n_fail = 0;
   idex_t exp_q[$];

   decode_stage dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_if_id_pc         (if_id_pc),
      .i_if_id_instr      (if_id_instr),
      .i_wb_we            (wb_we),
      .i_wb_addr          (wb_addr),
      .i_wb_data          (wb_data),
      .i_ex_mem_rd        (ex_mem_rd),
      .i_ex_mem_we        (ex_mem_we),
      .i_ex_mem_mem_rd    (ex_mem_mem_rd),
      .i_ex_mem_alu       (ex_mem_alu),
      .o_brq_addr         (brq_addr),
      .o_jmp_addr         (jmp_addr),
      .o_ctr_beq          (ctr_beq),
      .o_ctr_jmp          (ctr_jmp),
      .o_ctr_flush        (ctr_flush),
      .o_pc_we            (pc_we),
      .o_if_id_we         (if_id_we),
      .o_id_ex_pc         (dut_v.pc),
      .o_id_ex_rs_data    (dut_v.rs_data),
      .o_id_ex_rt_data    (dut_v.rt_data),
      .o_id_ex_imm        (dut_v.imm),
      .o_id_ex_rs         (dut_v.rs),
      .o_id_ex_rt         (dut_v.rt),
      .o_id_ex_rd         (dut_v.rd),
      .o_id_ex_alu_op     (dut_v.alu_op),
      .o_id_ex_alu_src    (dut_v.alu_src),
      .o_id_ex_mem_rd     (dut_v.mem_rd),
      .o_id_ex_mem_wr     (dut_v.mem_wr),
      .o_id_ex_reg_we     (dut_v.reg_we),
      .o_id_ex_mem_to_reg (dut_v.mem_to_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic idex_t mk(logic [31:0] pc, logic [31:0] rsd, logic [31:0] rtd,
                                logic [31:0] imm, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [3:0] op, logic src,
                                logic mrd, logic mwr, logic we, logic m2r);
      idex_t e;
      e = '{pc, rsd, rtd, imm, rs, rt, rd, op, src, mrd, mwr, we, m2r};
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // fetch-control checks: stall/branch/jump flags seen at mid-cycle
   task automatic comb(input string nm, input logic pw, input logic b, input logic j);
      chk({nm, ".pc_we"},    32'(pc_we),     32'(pw));
      chk({nm, ".if_id_we"}, 32'(if_id_we),  32'(pw));
      chk({nm, ".beq"},      32'(ctr_beq),   32'(b));
      chk({nm, ".jmp"},      32'(ctr_jmp),   32'(j));
      chk({nm, ".flush"},    32'(ctr_flush), 32'(b | j));
   endtask

   // advance to just after the next rising edge, where new inputs go on
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic mid();
      #3;
   endtask

   // monitor: each edge, the oldest expectation is due on the ID/EX outputs
   initial begin
      idex_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (dut_v !== e) begin
               n_fail++;
               $display("FAIL idex pc=%h: got %h expected %h", e.pc, dut_v, e);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      if_id_pc = '0; if_id_instr = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      ex_mem_rd = '0; ex_mem_we = 1'b0; ex_mem_mem_rd = 1'b0; ex_mem_alu = '0;
      if_id_instr = 32'h20080005;
      cyc(); cyc(); mid();
      chk("rst.idex_hi", dut_v[151:120], 32'h0);
      chk("rst.idex_lo", 32'(dut_v[31:0]), 32'h0);
      chk("rst.idex_any", 32'(|dut_v), 32'h0);
      comb("rst", 1'b1, 1'b0, 1'b0);

      // addi $8,$0,5
      cyc(); rst = 1'b1; if_id_pc = 32'h4; if_id_instr = 32'h20080005;
      exp_q.push_back(mk(32'h4, 0, 0, 32'h5, 0, 8, 8, 0, 1, 0, 0, 1, 0));
      mid(); comb("addi", 1'b1, 1'b0, 1'b0);

      // add $10,$9,$0 with $9 arriving on the WB port the same cycle
      cyc(); if_id_pc = 32'h8; if_id_instr = 32'h01205020;
      wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
      exp_q.push_back(mk(32'h8, 32'h1234, 0, 32'h5020, 9, 0, 10, 0, 0, 0, 0, 1, 0));
      mid(); comb("add_wb", 1'b1, 1'b0, 1'b0);

      // lw $2,0($1)
      cyc(); wb_we = 1'b0; if_id_pc = 32'hC; if_id_instr = 32'h8C220000;
      exp_q.push_back(mk(32'hC, 0, 0, 0, 1, 2, 2, 0, 1, 1, 0, 1, 1));
      mid(); comb("lw", 1'b1, 1'b0, 1'b0);

      // add $3,$2,$2: load-use stall then issue
      cyc(); if_id_pc = 32'h10; if_id_instr = 32'h00421820;
      exp_q.push_back('0);
      mid(); comb("lduse_stall", 1'b0, 1'b0, 1'b0);
      cyc();
      exp_q.push_back(mk(32'h10, 0, 0, 32'h1820, 2, 2, 3, 0, 0, 0, 0, 1, 0));
      mid(); comb("lduse_issue", 1'b1, 1'b0, 1'b0);

      // beq $4,$4,+3 at 0x20 -> taken, target 0x2C
      cyc(); if_id_pc = 32'h20; if_id_instr = 32'h10840003;
      exp_q.push_back(mk(32'h20, 0, 0, 32'h3, 4, 4, 0, 1, 0, 0, 0, 0, 0));
      mid(); comb("beq_eq", 1'b1, 1'b1, 1'b0);
      chk("beq_eq.brq", brq_addr, 32'h2C);

      // bne $4,$4,+3 -> not taken
      cyc(); if_id_pc = 32'h24; if_id_instr = 32'h14840003;
      exp_q.push_back(mk(32'h24, 0, 0, 32'h3, 4, 4, 0, 1, 0, 0, 0, 0, 0));
      mid(); comb("bne_eq", 1'b1, 1'b0, 1'b0);
      chk("bne_eq.brq", brq_addr, 32'h30);

      // j 0x40 at 0x10000004 while WB tries to write $0
      cyc(); if_id_pc = 32'h10000004; if_id_instr = 32'h08000040;
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
      exp_q.push_back(mk(32'h10000004, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      mid(); comb("jmp", 1'b1, 1'b0, 1'b1);
      chk("jmp.addr", jmp_addr, 32'h10000100);

      // addi $8,$0,5 again: $0 must still read 0
      cyc(); wb_we = 1'b0; if_id_pc = 32'h28; if_id_instr = 32'h20080005;
      exp_q.push_back(mk(32'h28, 0, 0, 32'h5, 0, 8, 8, 0, 1, 0, 0, 1, 0));
      mid(); comb("r0", 1'b1, 1'b0, 1'b0);

      // beq $5,$6,+2: $5 forwarded from EX/MEM (7), $6=7 via WB bypass
      cyc(); if_id_pc = 32'h40; if_id_instr = 32'h10A60002;
      ex_mem_we = 1'b1; ex_mem_rd = 5'd5; ex_mem_alu = 32'h7;
      wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h7;
      exp_q.push_back(mk(32'h40, 0, 32'h7, 32'h2, 5, 6, 0, 1, 0, 0, 0, 0, 0));
      mid(); comb("beq_fwd", 1'b1, 1'b1, 1'b0);
      chk("beq_fwd.brq", brq_addr, 32'h48);

      // same branch, EX/MEM is now a load -> stall, not taken
      cyc(); wb_we = 1'b0; ex_mem_mem_rd = 1'b1;
      exp_q.push_back('0);
      mid(); comb("beq_ldhaz", 1'b0, 1'b0, 1'b0);

      // addi $8 then beq $8,$8,+1 -> one stall cycle, then taken
      cyc(); ex_mem_we = 1'b0; ex_mem_mem_rd = 1'b0; ex_mem_rd = '0; ex_mem_alu = '0;
      if_id_pc = 32'h50; if_id_instr = 32'h20080005;
      exp_q.push_back(mk(32'h50, 0, 0, 32'h5, 0, 8, 8, 0, 1, 0, 0, 1, 0));
      mid(); comb("addi2", 1'b1, 1'b0, 1'b0);
      cyc(); if_id_pc = 32'h54; if_id_instr = 32'h11080001;
      exp_q.push_back('0);
      mid(); comb("beq_exhaz", 1'b0, 1'b0, 1'b0);
      cyc();
      exp_q.push_back(mk(32'h54, 0, 0, 32'h1, 8, 8, 0, 1, 0, 0, 0, 0, 0));
      mid(); comb("beq_after", 1'b1, 1'b1, 1'b0);
      chk("beq_after.brq", brq_addr, 32'h58);

      // undefined opcode -> NOP control
      cyc(); if_id_pc = 32'h60; if_id_instr = 32'hFC000000;
      exp_q.push_back(mk(32'h60, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      mid(); comb("undef", 1'b1, 1'b0, 1'b0);

      // slt $11,$9,$0 reads $9 from the register file
      cyc(); if_id_pc = 32'h64; if_id_instr = 32'h0120582A;
      exp_q.push_back(mk(32'h64, 32'h1234, 0, 32'h582A, 9, 0, 11, 4, 0, 0, 0, 1, 0));
      mid(); comb("slt", 1'b1, 1'b0, 1'b0);

      // sw $9,4($0)
      cyc(); if_id_pc = 32'h68; if_id_instr = 32'hAC090004;
      exp_q.push_back(mk(32'h68, 0, 32'h1234, 32'h4, 0, 9, 0, 0, 1, 0, 1, 0, 0));
      mid(); comb("sw", 1'b1, 1'b0, 1'b0);

      // negative immediate sign extension: addi $8,$0,-4
      cyc(); if_id_pc = 32'h6C; if_id_instr = 32'h2008FFFC;
      exp_q.push_back(mk(32'h6C, 0, 0, 32'hFFFFFFFC, 0, 8, 8, 0, 1, 0, 0, 1, 0));
      mid(); comb("addi_neg", 1'b1, 1'b0, 1'b0);
      chk("addi_neg.brq", brq_addr, 32'h5C);

      cyc(); if_id_pc = '0; if_id_instr = '0;
      cyc(); cyc();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
